obi_ext_sram_bridge: RTL

Responder for the core's instruction and data OBI-style request/grant/rvalid ports and initiator on the byte-wide external SRAM port of the chip top. It arbitrates the two core ports and turns each granted 32-bit access into four sequential byte accesses on the external SRAM. It then returns read data with a single rvalid pulse. It sits between `ibex_top` and the `ext_sram_*` pads inside `ibex_chiptop`.

---
 rtl/obi_ext_sram_bridge_pkg.sv | 18 +
 rtl/obi_rr_arb2.sv | 37 +++
 rtl/obi_ext_sram_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/obi_ext_sram_bridge_pkg.sv
// Shared types for the OBI-to-byte-wide external SRAM bridge.
package obi_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TAIL,
    RESP
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

endpackage

// File: rtl/obi_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = instr, bit 1 = data.
module obi_rr_arb2
  import obi_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       winner
);

  port_t last;
  port_t pick;

  // Pick the sole requester, or on a tie the port that did not win last time.
  always_comb begin
    pick = PORT_DATA;
    case (req)
      2'b01:   pick = PORT_INSTR;
      2'b10:   pick = PORT_DATA;
      2'b11:   pick = (last == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
      default: pick = PORT_DATA;
    endcase
    gnt = '0;
    if (en && (req != 2'b00)) gnt[pick] = 1'b1;
  end

  assign winner = pick;

  // Remember the last granted port; reset to instr so data wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= PORT_INSTR;
    else if (|gnt) last <= pick;
  end

endmodule

// File: rtl/obi_ext_sram_bridge.sv
// Bridges the instr/data OBI ports onto a byte-wide external SRAM:
// one granted word access becomes four byte strobes, then one rvalid pulse.
module obi_ext_sram_bridge
  import obi_sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic [31:0]       data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic [ADDR_W-1:0] ext_sram_addr,
  output logic              ext_sram_read,
  output logic              ext_sram_write,
  output logic [7:0]        ext_sram_wdata,
  input  logic [7:0]        ext_sram_rdata
);

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;

  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  port_t       port_q;

  logic [31:0] rbuf;
  logic        rd_pend;
  logic [1:0]  rd_idx;

  logic [1:0]  arb_gnt;
  logic        arb_winner;

  logic [29:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  logic [31:0]       strobe_addr;
  logic [ADDR_W-1:0] addr_n;
  logic              read_n;
  logic              write_n;
  logic [7:0]        wdata_n;

  // Word-aligned access only; the top byte of rbuf feeds straight through on RESP entry.
  logic unused_bits;
  assign unused_bits = ^{instr_addr_i[1:0], data_addr_i[1:0], rbuf[31:24]};

  obi_rr_arb2 u_arb (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .en     (state == IDLE),
    .req    ({data_req_i, instr_req_i}),
    .gnt    (arb_gnt),
    .winner (arb_winner)
  );

  assign instr_gnt_o = arb_gnt[0];
  assign data_gnt_o  = arb_gnt[1];

  // Select the winning port's request; fetches are full-word loads.
  always_comb begin
    if (arb_winner == PORT_DATA) begin
      req_addr  = data_addr_i[31:2];
      req_we    = data_we_i;
      req_be    = data_be_i;
      req_wdata = data_wdata_i;
    end else begin
      req_addr  = instr_addr_i[31:2];
      req_we    = 1'b0;
      req_be    = 4'hF;
      req_wdata = '0;
    end
  end

  // Byte sequencer: next state plus next values of the registered strobe outputs.
  // Strobes for lane k are computed one cycle early so they appear registered.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    strobe_addr = '0;
    addr_n      = ext_sram_addr;
    read_n      = 1'b0;
    write_n     = 1'b0;
    wdata_n     = ext_sram_wdata;
    case (state)
      IDLE: begin
        if (|arb_gnt) begin
          state_n     = XFER;
          idx_n       = '0;
          strobe_addr = {req_addr, 2'b00};
          addr_n      = strobe_addr[ADDR_W-1:0];
          read_n      = !req_we;
          write_n     = req_we & req_be[0];
          wdata_n     = req_wdata[7:0];
        end
      end
      XFER: begin
        if (idx == 2'(BYTES_PER_WORD - 1)) begin
          state_n = TAIL;
        end else begin
          idx_n       = idx + 2'd1;
          strobe_addr = {addr_q, idx_n};
          addr_n      = strobe_addr[ADDR_W-1:0];
          read_n      = !we_q;
          write_n     = we_q & be_q[idx_n];
          wdata_n     = wdata_q[8*idx_n +: 8];
        end
      end
      TAIL:    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and lane index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Latch the granted request for the duration of the transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      port_q  <= PORT_INSTR;
    end else if ((state == IDLE) && (|arb_gnt)) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      be_q    <= req_be;
      wdata_q <= req_wdata;
      port_q  <= port_t'(arb_winner);
    end
  end

  // Registered external SRAM strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_sram_addr  <= '0;
      ext_sram_read  <= 1'b0;
      ext_sram_write <= 1'b0;
      ext_sram_wdata <= '0;
    end else begin
      ext_sram_addr  <= addr_n;
      ext_sram_read  <= read_n;
      ext_sram_write <= write_n;
      ext_sram_wdata <= wdata_n;
    end
  end

  // Read bytes arrive the cycle after their strobe; capture them into their lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend <= 1'b0;
      rd_idx  <= '0;
      rbuf    <= '0;
    end else begin
      rd_pend <= ext_sram_read;
      rd_idx  <= idx;
      if (rd_pend) rbuf[8*rd_idx +: 8] <= ext_sram_rdata;
    end
  end

  // Response: one rvalid pulse on the owner; loads update that port's rdata.
  // The lane-3 byte is still on the bus when RESP is entered, so it bypasses rbuf.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      instr_rdata_o  <= '0;
      data_rdata_o   <= '0;
    end else begin
      instr_rvalid_o <= (state == TAIL) && (port_q == PORT_INSTR);
      data_rvalid_o  <= (state == TAIL) && (port_q == PORT_DATA);
      if ((state == TAIL) && !we_q) begin
        if (port_q == PORT_INSTR) instr_rdata_o <= {ext_sram_rdata, rbuf[23:0]};
        else data_rdata_o <= {ext_sram_rdata, rbuf[23:0]};
      end
    end
  end

endmodule
